// File: rtl/wb_burst_reader_if.sv
// Wishbone B4 master/slave bundle used by wb_burst_reader.
interface wb_burst_reader_if;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_ms;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic        wb_ack;
  logic [31:0] wb_dat_sm;

  modport master (
    output wb_adr, wb_dat_ms, wb_sel, wb_we, wb_cyc, wb_stb, wb_cti, wb_bte,
    input  wb_ack, wb_dat_sm
  );

  modport slave (
    input  wb_adr, wb_dat_ms, wb_sel, wb_we, wb_cyc, wb_stb, wb_cti, wb_bte,
    output wb_ack, wb_dat_sm
  );
endinterface

// File: rtl/wb_burst_reader.sv
// Wishbone burst read master draining a contiguous word run into a stream FIFO.
// Define WB_BURST_READER_CLASSIC_EN to issue classic (cti=000) cycles instead of incrementing bursts.
module wb_burst_reader #(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       base_adr,
  input  logic [CNT_W-1:0]  nwords,
  output logic              busy,
  output logic              done,
  output logic [31:0]       m_data,
  output logic              m_valid,
  input  logic              m_ready,
  wb_burst_reader_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef WB_BURST_READER_CLASSIC_EN
  localparam logic [2:0] CTI_MID = 3'b000;
  localparam logic [2:0] CTI_END = 3'b000;
`else
  localparam logic [2:0] CTI_MID = 3'b010;
  localparam logic [2:0] CTI_END = 3'b111;
`endif

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_BURST, S_DRAIN, S_FINISH} state_t;

  state_t           state_q, state_d;
  logic [31:0]      adr_q, adr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CW-1:0]    beat_q, beat_d, blen_q, blen_d, cnt_q, cnt_d;
  logic [CW-1:0]    free, blen;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             cyc_q, cyc_d, done_q, done_d, busy_q, busy_d;
  logic [2:0]       cti_q, cti_d;
  logic             push, pop;
  logic [31:0]      fifo_mem [FIFO_DEPTH];

  always_comb begin
    pop      = (cnt_q != '0) && m_ready;
    push     = (state_q == S_BURST) && bus.wb_ack;
    // space freed by this cycle's pop counts, so a burst can launch a cycle earlier
    free     = CW'(FIFO_DEPTH) - cnt_q + CW'(pop);
    blen     = (rem_q >= CNT_W'(BURST_LEN)) ? CW'(BURST_LEN) : CW'(rem_q);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    state_d  = state_q;
    adr_d    = adr_q;
    rem_d    = rem_q;
    beat_d   = beat_q;
    blen_d   = blen_q;
    cyc_d    = cyc_q;
    cti_d    = cti_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        if (nwords != '0) begin
          adr_d   = base_adr & ~32'd3;
          rem_d   = nwords;
          state_d = S_WAIT;
        end else begin
          state_d = S_FINISH;
          done_d  = 1'b1;
        end
      end
      S_WAIT: if (free >= blen) begin
        state_d = S_BURST;
        cyc_d   = 1'b1;
        blen_d  = blen;
        beat_d  = '0;
        cti_d   = (blen == CW'(1)) ? CTI_END : CTI_MID;
      end
      S_BURST: if (bus.wb_ack) begin
        adr_d  = adr_q + 32'd4;
        rem_d  = rem_q - 1'b1;
        beat_d = beat_q + 1'b1;
        if (beat_q == blen_q - 1'b1) begin
          cyc_d   = 1'b0;
          cti_d   = 3'b000;
          state_d = (rem_q == CNT_W'(1)) ? S_DRAIN : S_WAIT;
        end else begin
          cti_d = (beat_q + CW'(2) == blen_q) ? CTI_END : CTI_MID;
        end
      end
      S_DRAIN: if (cnt_q == '0) begin
        state_d = S_FINISH;
        done_d  = 1'b1;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      adr_q    <= '0;
      rem_q    <= '0;
      beat_q   <= '0;
      blen_q   <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cyc_q    <= 1'b0;
      cti_q    <= 3'b000;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      assert (!(push && !pop && cnt_q == CW'(FIFO_DEPTH)));
      state_q  <= state_d;
      adr_q    <= adr_d;
      rem_q    <= rem_d;
      beat_q   <= beat_d;
      blen_q   <= blen_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cyc_q    <= cyc_d;
      cti_q    <= cti_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr_q] <= bus.wb_dat_sm;

  assign m_data        = fifo_mem[rd_ptr_q];
  assign m_valid       = (cnt_q != '0);
  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.wb_adr    = adr_q;
  assign bus.wb_cyc    = cyc_q;
  assign bus.wb_stb    = cyc_q;
  assign bus.wb_cti    = cti_q;
  assign bus.wb_dat_ms = 32'd0;
  assign bus.wb_sel    = 4'b1111;
  assign bus.wb_we     = 1'b0;
  assign bus.wb_bte    = 2'b00;
endmodule

// File: tb/tb_wb_burst_reader.sv
// Randomized bench for wb_burst_reader: behavioural slave + word-queue scoreboard.
module tb_wb_burst_reader;
  localparam int BL = 8, DEPTH = 16, CNT_W = 16;

  logic             clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0]      base_adr = '0;
  logic [CNT_W-1:0] nwords = '0;
  logic             busy, done, m_valid, m_ready = 1'b0;
  logic [31:0]      m_data;

  wb_burst_reader_if bus();

  wb_burst_reader #(.BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_adr(base_adr), .nwords(nwords),
    .busy(busy), .done(done), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_pass = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_base = '0, salt = 32'h5A5A_1234;
  int          exp_n = 0, beat_k = 0, occ = 0, n_pop = 0, stb_cnt = 0;
  int          ack_mode = 0, rdy_mode = 0, rst_beat = -1;
  bit          prev_last = 1'b0, rst_req = 1'b0, ack_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] wdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  function automatic bit last_of_burst(input int k);
    return ((k % BL) == BL - 1) || (k == exp_n - 1);
  endfunction

  function automatic logic [2:0] exp_cti(input int k);
`ifdef WB_BURST_READER_CLASSIC_EN
    return 3'b000;
`else
    return last_of_burst(k) ? 3'b111 : 3'b010;
`endif
  endfunction

  // Slave + sink model: drives ack/ready on the falling edge and scores what the DUT shows.
  always @(negedge clk) begin
    if (rst) begin
      bus.wb_ack = 1'b0;
      m_ready    = 1'b0;
      exp_q.delete();
      occ = 0; beat_k = 0; prev_last = 1'b0;
    end else begin
      chk("m_valid", m_valid, occ != 0);
      if (prev_last) chk("burst_gap", bus.wb_cyc, 0);
      prev_last = 1'b0;
      if (done) chk("done_drained", (occ == 0) && (exp_q.size() == 0), 1);
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("data_extra", 1, 0);
        else chk("data", m_data, exp_q.pop_front());
        n_pop++; occ--;
      end
      ack_n = 1'b0;
      if (bus.wb_cyc) begin
        chk("stb", bus.wb_stb, 1);
        chk("adr", bus.wb_adr, exp_base + 32'(4 * beat_k));
        chk("cti", bus.wb_cti, exp_cti(beat_k));
        chk("beat_range", beat_k < exp_n, 1);
        stb_cnt++;
        case (ack_mode)
          0:       ack_n = 1'b1;
          1:       ack_n = 1'($urandom_range(0, 1));
          default: ack_n = (stb_cnt % 3 == 0);
        endcase
      end
      bus.wb_ack    = ack_n;
      bus.wb_dat_sm = ack_n ? wdata(bus.wb_adr) : $urandom;
      if (ack_n) begin
        if (last_of_burst(beat_k)) prev_last = 1'b1;
        if (beat_k == rst_beat) begin rst_req = 1'b1; rst_beat = -1; end
        beat_k++; occ++;
        chk("no_overflow", occ <= DEPTH, 1);
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic start_xfer(input logic [31:0] base, input int n, input int am, input int rm);
    exp_base = base & ~32'd3; exp_n = n;
    beat_k = 0; n_pop = 0; stb_cnt = 0;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(wdata(exp_base + 32'(4 * i)));
    ack_mode = am; rdy_mode = rm;
    base_adr = base; nwords = CNT_W'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input bit poke);
    bit got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      if (done) got = 1'b1;
      else begin
        if (poke && c == 6) begin
          chk("busy_mid", busy, 1);
          base_adr = 32'hDEAD_0000; nwords = CNT_W'(3); start = 1'b1;
        end
        tick();
        start = 1'b0;
      end
    end
    chk("done_seen", got, 1);
    tick();
    chk("busy_after", busy, 0);
    chk("done_pulse", done, 0);
    chk("words_out", n_pop, n);
    if (n > 0) chk("end_adr", bus.wb_adr, exp_base + 32'(4 * n));
  endtask

  initial begin
    bus.wb_ack = 1'b0; bus.wb_dat_sm = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cyc", bus.wb_cyc, 0);
    chk("rst_stb", bus.wb_stb, 0);
    chk("rst_cti", bus.wb_cti, 3'b000);
    chk("rst_adr", bus.wb_adr, 0);
    chk("rst_mvalid", m_valid, 0);
    rst = 1'b0;
    tick();

    // basic burst, short tail, slow slave, misaligned base, address wrap
    start_xfer(32'h100, 8, 0, 0);  wait_done(8, 0);
    start_xfer(32'h100, 11, 0, 0); wait_done(11, 0);
    start_xfer(32'h200, 5, 2, 0);  wait_done(5, 0);
    start_xfer(32'h303, 3, 0, 1);  wait_done(3, 0);
    start_xfer(32'hFFFF_FFF4, 12, 1, 1); wait_done(12, 0);
    start_xfer(32'h0, 1, 2, 0);    wait_done(1, 0);

    // zero-length command
    start_xfer(32'h400, 0, 0, 0);
    chk("zero_done", done, 1);
    wait_done(0, 0);

    // backpressure: only a FIFO's worth is fetched while the sink stalls
    start_xfer(32'h4000, 40, 0, 2);
    repeat (80) tick();
    chk("bp_fetched", beat_k, DEPTH);
    chk("bp_cyc", bus.wb_cyc, 0);
    chk("bp_busy", busy, 1);
    rdy_mode = 0;
    wait_done(40, 0);

    // start while busy is ignored
    start_xfer(32'h800, 30, 2, 1); wait_done(30, 1);

    // reset on the 4th beat
    rst_beat = 3;
    start_xfer(32'h100, 8, 0, 0);
    for (int c = 0; c < 200 && !rst_req; c++) tick();
    chk("rst_trigger", rst_req, 1);
    rst = 1'b1; rst_req = 1'b0;
    tick();
    chk("mid_rst_cyc", bus.wb_cyc, 0);
    chk("mid_rst_stb", bus.wb_stb, 0);
    chk("mid_rst_mvalid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    start_xfer(32'h100, 8, 0, 0); wait_done(8, 0);

    for (int i = 0; i < 8; i++) begin
      int n;
      n = int'($urandom_range(1, 40));
      start_xfer($urandom, n, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
      wait_done(n, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
